// File: rtl/instruction_fetch_queue.sv
// Instruction fetch unit: PC sequencing with JAL/branch prediction, icache/memory
// fetch FSM and a circular queue of {pc, inst, pred} feeding the decoder.
module instruction_fetch_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clr_in,
    input  logic [ADDR_W-1:0]            clr_pc,
    output logic [ADDR_W-1:0]            ic_fetch_addr,
    input  logic                         ic_hit,
    input  logic [INST_W-1:0]            ic_hit_inst,
    output logic                         ic_upd_valid,
    output logic [ADDR_W-1:0]            ic_upd_addr,
    output logic [INST_W-1:0]            ic_upd_inst,
    output logic                         mc_req_valid,
    output logic [ADDR_W-1:0]            mc_req_addr,
    input  logic                         mc_req_accept,
    input  logic                         mc_resp_valid,
    input  logic [INST_W-1:0]            mc_resp_inst,
    output logic [ADDR_W-1:0]            pr_pc,
    input  logic                         pr_taken,
    output logic                         dc_valid,
    input  logic                         dc_ready,
    output logic [ADDR_W-1:0]            dc_pc,
    output logic [INST_W-1:0]            dc_inst,
    output logic                         dc_pred,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MC,
        DROP
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] pc, pc_nx, next_pc;
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  cnt;
    logic              full;
    logic              push, pop;
    logic              req_nx, upd_nx;

    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic              q_pred [DEPTH];

    logic [INST_W-1:0] fetch_inst;
    logic [6:0]        opcode;
    logic              is_jal, is_br, pred;
    logic [ADDR_W-1:0] j_imm, b_imm;

    assign ic_fetch_addr = pc;
    assign pr_pc         = pc;
    assign mc_req_addr   = pc;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign dc_valid = (cnt != '0);
    assign dc_pc    = q_pc[head];
    assign dc_inst  = q_inst[head];
    assign dc_pred  = q_pred[head];
    assign count    = cnt;

    // Only IDLE pushes from the icache; WAIT_MC pushes the memory response.
    assign fetch_inst = (state == IDLE) ? ic_hit_inst : mc_resp_inst;
    assign opcode     = fetch_inst[6:0];
    assign is_jal     = (opcode == 7'b1101111);
    assign is_br      = (opcode == 7'b1100011);
    assign pred       = is_jal | (is_br & pr_taken);

    assign j_imm = {{(ADDR_W-21){fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                    fetch_inst[20], fetch_inst[30:21], 1'b0};
    assign b_imm = {{(ADDR_W-13){fetch_inst[31]}}, fetch_inst[31], fetch_inst[7],
                    fetch_inst[30:25], fetch_inst[11:8], 1'b0};

    always_comb begin
        next_pc = pc + ADDR_W'(4);
        if (is_jal) begin
            next_pc = pc + j_imm;
        end else if (is_br && pr_taken) begin
            next_pc = pc + b_imm;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        push     = 1'b0;
        pop      = dc_valid && dc_ready;
        req_nx   = mc_req_valid;
        upd_nx   = 1'b0;
        if (clr_in) begin
            pop    = 1'b0;
            req_nx = 1'b0;
            pc_nx  = clr_pc;
            case (state)
                IDLE:    if (mc_req_valid && mc_req_accept) state_nx = DROP;
                // A response coinciding with the flush is the stale one itself.
                default: state_nx = mc_resp_valid ? IDLE : DROP;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (mc_req_valid) begin
                        if (mc_req_accept) begin
                            req_nx   = 1'b0;
                            state_nx = WAIT_MC;
                        end
                    end else if (!full) begin
                        if (ic_hit) begin
                            push  = 1'b1;
                            pc_nx = next_pc;
                        end else begin
                            req_nx = 1'b1;
                        end
                    end
                end
                WAIT_MC: begin
                    if (mc_resp_valid) begin
                        push     = 1'b1;
                        upd_nx   = 1'b1;
                        pc_nx    = next_pc;
                        state_nx = IDLE;
                    end
                end
                DROP: begin
                    if (mc_resp_valid) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc           <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            cnt          <= '0;
            mc_req_valid <= 1'b0;
            ic_upd_valid <= 1'b0;
            ic_upd_addr  <= '0;
            ic_upd_inst  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
                q_pred[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            pc           <= pc_nx;
            mc_req_valid <= req_nx;
            ic_upd_valid <= upd_nx;
            if (upd_nx) begin
                ic_upd_addr <= pc;
                ic_upd_inst <= mc_resp_inst;
            end
            if (clr_in) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (push) begin
                    q_pc[tail]   <= pc;
                    q_inst[tail] <= fetch_inst;
                    q_pred[tail] <= pred;
                    tail         <= tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: fill/stall, JAL and branch prediction,
// memory miss path, flush with stale-response drop, pointer wrap, rdy_in freeze, reset.
module tb_instruction_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic [31:0] clr_pc;
    logic [31:0] ic_fetch_addr;
    logic        ic_hit;
    logic [31:0] ic_hit_inst;
    logic        ic_upd_valid;
    logic [31:0] ic_upd_addr;
    logic [31:0] ic_upd_inst;
    logic        mc_req_valid;
    logic [31:0] mc_req_addr;
    logic        mc_req_accept;
    logic        mc_resp_valid;
    logic [31:0] mc_resp_inst;
    logic [31:0] pr_pc;
    logic        pr_taken;
    logic        dc_valid;
    logic        dc_ready;
    logic [31:0] dc_pc;
    logic [31:0] dc_inst;
    logic        dc_pred;
    logic [2:0]  count;

    int compared = 0;
    int mismatched = 0;

    localparam logic [31:0] JAL_I  = 32'h1000006F;  // jal x0, +0x100
    localparam logic [31:0] BEQ_I  = 32'h00000463;  // beq x0, x0, +8
    localparam logic [31:0] MEM_I  = 32'h00500093;
    localparam logic [31:0] STALE  = 32'h00700093;

    instruction_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc(clr_pc),
        .ic_fetch_addr(ic_fetch_addr), .ic_hit(ic_hit), .ic_hit_inst(ic_hit_inst),
        .ic_upd_valid(ic_upd_valid), .ic_upd_addr(ic_upd_addr), .ic_upd_inst(ic_upd_inst),
        .mc_req_valid(mc_req_valid), .mc_req_addr(mc_req_addr), .mc_req_accept(mc_req_accept),
        .mc_resp_valid(mc_resp_valid), .mc_resp_inst(mc_resp_inst),
        .pr_pc(pr_pc), .pr_taken(pr_taken),
        .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_pc(dc_pc), .dc_inst(dc_inst),
        .dc_pred(dc_pred), .count(count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] addi(input int unsigned k);
        return 32'h00000093 | (k << 20);
    endfunction

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0; clr_pc = '0;
        ic_hit = 1'b0; ic_hit_inst = '0; mc_req_accept = 1'b0; mc_resp_valid = 1'b0;
        mc_resp_inst = '0; pr_taken = 1'b0; dc_ready = 1'b0;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_dc_valid", dc_valid, 0);
        chk("rst_req", mc_req_valid, 0);
        chk("rst_upd", ic_upd_valid, 0);
        chk("rst_pc", ic_fetch_addr, 32'h0);
        chk("rst_dc_pc", dc_pc, 32'h0);

        // Fill the queue with hits, decoder stalled.
        rst_in = 1'b1; ic_hit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ic_hit_inst = addi(k);
            step();
            chk("fill_count", count, k + 1);
            chk("fill_pc", ic_fetch_addr, 4 * (k + 1));
        end
        step(); step();
        chk("full_count", count, 4);
        chk("full_pc", ic_fetch_addr, 32'h10);
        chk("full_noreq", mc_req_valid, 0);
        chk("full_head_pc", dc_pc, 32'h0);
        chk("full_head_inst", dc_inst, addi(0));

        // Drain while hitting: full blocks the push in the first pop cycle.
        dc_ready = 1'b1; ic_hit_inst = JAL_I;
        step();
        chk("fullpop_count", count, 3);
        chk("fullpop_dc_pc", dc_pc, 32'h4);
        chk("fullpop_pc", ic_fetch_addr, 32'h10);
        step();
        chk("jal_count", count, 3);
        chk("jal_dc_pc", dc_pc, 32'h8);
        chk("jal_next_pc", ic_fetch_addr, 32'h110);
        chk("jal_pr_pc", pr_pc, 32'h110);
        ic_hit_inst = addi(5);
        step();
        chk("wrap_dc_pc0", dc_pc, 32'hC);
        chk("wrap_pc0", ic_fetch_addr, 32'h114);
        step();
        chk("wrap_dc_pc1", dc_pc, 32'h10);
        chk("wrap_dc_inst", dc_inst, JAL_I);
        chk("wrap_dc_pred", dc_pred, 1);
        chk("wrap_count", count, 3);

        // Flush to 0x20 and take a memory miss there.
        clr_in = 1'b1; clr_pc = 32'h20; ic_hit = 1'b0; dc_ready = 1'b0;
        step();
        clr_in = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_dc_valid", dc_valid, 0);
        chk("clr_pc", ic_fetch_addr, 32'h20);
        chk("clr_noreq", mc_req_valid, 0);
        step();
        chk("miss_req", mc_req_valid, 1);
        chk("miss_addr", mc_req_addr, 32'h20);
        step();
        chk("miss_req_held", mc_req_valid, 1);
        mc_req_accept = 1'b1;
        step();
        mc_req_accept = 1'b0;
        chk("acc_req_drop", mc_req_valid, 0);
        step();
        step();
        chk("wait_count", count, 0);
        mc_resp_valid = 1'b1; mc_resp_inst = MEM_I;
        step();
        mc_resp_valid = 1'b0;
        chk("resp_count", count, 1);
        chk("resp_upd", ic_upd_valid, 1);
        chk("resp_upd_addr", ic_upd_addr, 32'h20);
        chk("resp_upd_inst", ic_upd_inst, MEM_I);
        chk("resp_pc", ic_fetch_addr, 32'h24);
        chk("resp_dc_pc", dc_pc, 32'h20);
        chk("resp_dc_inst", dc_inst, MEM_I);
        step();
        chk("upd_pulse_end", ic_upd_valid, 0);
        chk("miss2_addr", mc_req_addr, 32'h24);
        mc_req_accept = 1'b1;
        step();
        mc_req_accept = 1'b0;

        // Flush while waiting on memory: the late response must be dropped.
        clr_in = 1'b1; clr_pc = 32'h400;
        step();
        clr_in = 1'b0;
        chk("drop_count", count, 0);
        chk("drop_pc", ic_fetch_addr, 32'h400);
        step();
        chk("drop_noreq", mc_req_valid, 0);
        mc_resp_valid = 1'b1; mc_resp_inst = STALE;
        step();
        mc_resp_valid = 1'b0;
        chk("stale_count", count, 0);
        chk("stale_upd", ic_upd_valid, 0);
        chk("stale_pc", ic_fetch_addr, 32'h400);
        ic_hit = 1'b1; ic_hit_inst = addi(9);
        step();
        chk("refetch_dc_pc", dc_pc, 32'h400);
        chk("refetch_pc", ic_fetch_addr, 32'h404);

        // Streaming hits with a 5-cycle rdy_in freeze.
        dc_ready = 1'b1;
        step();
        chk("stream_dc_pc", dc_pc, 32'h404);
        rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("frz_count", count, 1);
            chk("frz_dc_pc", dc_pc, 32'h404);
            chk("frz_pc", ic_fetch_addr, 32'h408);
        end
        rdy_in = 1'b1;
        step();
        chk("resume_dc_pc0", dc_pc, 32'h408);
        chk("resume_pc0", ic_fetch_addr, 32'h40C);
        step();
        chk("resume_dc_pc1", dc_pc, 32'h40C);
        chk("resume_count", count, 1);

        // Branch prediction: taken then not taken.
        ic_hit_inst = BEQ_I; pr_taken = 1'b1;
        step();
        chk("br_t_dc_pred", dc_pred, 1);
        chk("br_t_pc", ic_fetch_addr, 32'h418);
        pr_taken = 1'b0;
        step();
        chk("br_nt_dc_pred", dc_pred, 0);
        chk("br_nt_dc_pc", dc_pc, 32'h418);
        chk("br_nt_pc", ic_fetch_addr, 32'h41C);

        // Reset in the middle of a pending request.
        ic_hit = 1'b0; dc_ready = 1'b0;
        step();
        chk("pre_rst_req", mc_req_valid, 1);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_req", mc_req_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_pc", ic_fetch_addr, 32'h0);
        step();
        rst_in = 1'b1; mc_resp_valid = 1'b1; mc_resp_inst = STALE;
        step();
        mc_resp_valid = 1'b0;
        chk("post_rst_count", count, 0);
        chk("post_rst_upd", ic_upd_valid, 0);
        chk("post_rst_req", mc_req_valid, 1);
        chk("post_rst_addr", mc_req_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
